// File: rtl/adc_sample_framer.sv
// Ping-pong framer: captures four 64-bit ADC lane words per DATA_READY and streams header, [TS], ch0..ch7.
// Define FRAMER_TIMESTAMP_EN to add a free-running 32-bit MCLK timestamp word after each header.
module adc_sample_framer #(
    parameter logic [7:0] HEADER_TAG = 8'hA5
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             nSYNC_IN,
    input  logic             DATA_READY,
    input  logic [3:0][63:0] DATA,
    output logic [31:0]      TDATA,
    output logic             TVALID,
    input  logic             TREADY,
    output logic             TLAST,
    output logic             OVERFLOW
);

`ifdef FRAMER_TIMESTAMP_EN
    typedef enum logic [1:0] {IDLE, HDR, TS, CH} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, CH} state_t;
`endif

    state_t      state;
    logic [2:0]  ch_idx;
    logic [1:0]  slot_full;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [15:0] frame_cnt;
    logic [31:0] ch_mem [2][8];
    logic [15:0] slot_num [2];
`ifdef FRAMER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] slot_ts [2];
`endif

    logic        handshake;
    logic        frame_done;
    logic        wr_free;
    logic        capture;
    logic        drop;
    logic [1:0]  full_eff;
    logic [31:0] hdr_word [2];

    // full_eff/hdr_word see a same-cycle capture, so a header can leave one cycle after DATA_READY.
    always_comb begin
        handshake  = TVALID && TREADY;
        frame_done = handshake && (state == CH) && (ch_idx == 3'd7);
        wr_free    = !slot_full[wr_ptr] || (frame_done && (wr_ptr == rd_ptr));
        capture    = DATA_READY && wr_free;
        drop       = DATA_READY && !wr_free;
        for (int unsigned s = 0; s < 2; s++) begin
            full_eff[s[0]] = slot_full[s[0]] || (capture && (wr_ptr == s[0]));
            hdr_word[s[0]] = {HEADER_TAG, 8'd8,
                              (capture && (wr_ptr == s[0])) ? frame_cnt : slot_num[s[0]]};
        end
    end

    always_ff @(posedge MCLK) begin
        if (capture) begin
            for (int unsigned k = 0; k < 8; k++) begin
                ch_mem[wr_ptr][k[2:0]] <= k[0] ? DATA[k[2:1]][31:0] : DATA[k[2:1]][63:32];
            end
            slot_num[wr_ptr] <= frame_cnt;
`ifdef FRAMER_TIMESTAMP_EN
            slot_ts[wr_ptr] <= ts_cnt;
`endif
        end
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            ch_idx    <= '0;
            slot_full <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            frame_cnt <= '0;
            OVERFLOW  <= 1'b0;
            TDATA     <= '0;
            TVALID    <= 1'b0;
            TLAST     <= 1'b0;
`ifdef FRAMER_TIMESTAMP_EN
            ts_cnt    <= '0;
`endif
        end else begin
            if (!nSYNC_IN) begin
                frame_cnt <= '0;
                OVERFLOW  <= 1'b0;
`ifdef FRAMER_TIMESTAMP_EN
                ts_cnt    <= '0;
`endif
            end else begin
                if (DATA_READY) frame_cnt <= frame_cnt + 16'd1;
                if (drop) OVERFLOW <= 1'b1;
`ifdef FRAMER_TIMESTAMP_EN
                ts_cnt <= ts_cnt + 32'd1;
`endif
            end

            // Set after clear: a capture into the slot freed this cycle must win.
            if (frame_done) slot_full[rd_ptr] <= 1'b0;
            if (capture) begin
                slot_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end

            case (state)
                IDLE: begin
                    if (full_eff[rd_ptr]) begin
                        state  <= HDR;
                        TVALID <= 1'b1;
                        TLAST  <= 1'b0;
                        TDATA  <= hdr_word[rd_ptr];
                    end
                end
                HDR: begin
                    if (handshake) begin
`ifdef FRAMER_TIMESTAMP_EN
                        state <= TS;
                        TDATA <= slot_ts[rd_ptr];
`else
                        state  <= CH;
                        ch_idx <= '0;
                        TDATA  <= ch_mem[rd_ptr][0];
`endif
                    end
                end
`ifdef FRAMER_TIMESTAMP_EN
                TS: begin
                    if (handshake) begin
                        state  <= CH;
                        ch_idx <= '0;
                        TDATA  <= ch_mem[rd_ptr][0];
                    end
                end
`endif
                CH: begin
                    if (handshake) begin
                        if (ch_idx == 3'd7) begin
                            rd_ptr <= ~rd_ptr;
                            ch_idx <= '0;
                            TLAST  <= 1'b0;
                            if (full_eff[~rd_ptr]) begin
                                state <= HDR;
                                TDATA <= hdr_word[~rd_ptr];
                            end else begin
                                state  <= IDLE;
                                TVALID <= 1'b0;
                                TDATA  <= '0;
                            end
                        end else begin
                            ch_idx <= ch_idx + 3'd1;
                            TDATA  <= ch_mem[rd_ptr][ch_idx + 3'd1];
                            TLAST  <= (ch_idx == 3'd6);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Randomized bench for adc_sample_framer against a word-queue model of the output stream.
`timescale 1ns/1ps
module tb_adc_sample_framer;

    localparam logic [7:0] TAG = 8'hA5;

    logic             mclk = 1'b0;
    logic             nrst;
    logic             nsync;
    logic             dready;
    logic [3:0][63:0] data;
    logic [31:0]      tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic             ovf;

    always #5 mclk = ~mclk;

    adc_sample_framer #(.HEADER_TAG(TAG)) dut (
        .MCLK       (mclk),
        .nRST       (nrst),
        .nSYNC_IN   (nsync),
        .DATA_READY (dready),
        .DATA       (data),
        .TDATA      (tdata),
        .TVALID     (tvalid),
        .TREADY     (tready),
        .TLAST      (tlast),
        .OVERFLOW   (ovf)
    );

    typedef struct {
        logic [31:0] w;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          frames_in;
    logic [15:0] fnum;
    logic        exp_ovf;
    logic [31:0] tcount;
    int          total;
    int          bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 4; k++) data[k] = {$urandom(), $urandom()};
    endtask

    task automatic push_frame();
        word_t e;
        e.w = {TAG, 8'd8, fnum};
        e.last = 1'b0;
        exp_q.push_back(e);
`ifdef FRAMER_TIMESTAMP_EN
        e.w = tcount;
        exp_q.push_back(e);
`endif
        for (int j = 0; j < 8; j++) begin
            e.w = (j % 2 == 0) ? data[j / 2][63:32] : data[j / 2][31:0];
            e.last = (j == 7);
            exp_q.push_back(e);
        end
        frames_in++;
    endtask

    task automatic check_outputs();
        check_eq("tvalid", 32'(tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("tdata", tdata, exp_q[0].w);
            check_eq("tlast", 32'(tlast), 32'(exp_q[0].last));
        end
        check_eq("overflow", 32'(ovf), 32'(exp_ovf));
    endtask

    // Called just after a falling edge: apply inputs, advance the model, clock once, check.
    task automatic tick(input logic dr, input logic rdy, input logic sync_n);
        word_t e;
        dready = dr;
        tready = rdy;
        nsync  = sync_n;
        if (exp_q.size() != 0 && rdy) begin
            e = exp_q.pop_front();
            if (e.last) frames_in--;
        end
        if (dr) begin
            if (frames_in < 2) push_frame();
            else exp_ovf = 1'b1;
            fnum++;
        end
        if (!sync_n) begin
            fnum    = '0;
            exp_ovf = 1'b0;
        end
        @(posedge mclk);
        tcount = sync_n ? tcount + 32'd1 : 32'd0;
        @(negedge mclk);
        dready = 1'b0;
        nsync  = 1'b1;
        check_outputs();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check_eq("rst_tvalid", 32'(tvalid), 32'd0);
        check_eq("rst_tlast", 32'(tlast), 32'd0);
        check_eq("rst_tdata", tdata, 32'd0);
        check_eq("rst_overflow", 32'(ovf), 32'd0);
        exp_q.delete();
        frames_in = 0;
        fnum      = '0;
        exp_ovf   = 1'b0;
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        nrst   = 1'b1;
        tcount = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic found;
        int   gap;
        total  = 0;
        bad    = 0;
        nrst   = 1'b0;
        nsync  = 1'b1;
        dready = 1'b0;
        tready = 1'b0;
        data   = '0;
        tcount = '0;
        @(negedge mclk);
        do_reset();

        // single frame with known lane-0 pattern
        rand_data();
        data[0] = 64'h11111111_22222222;
        tick(1'b1, 1'b1, 1'b1);
        check_eq("first_header", tdata, 32'hA508_0000);
        repeat (12) tick(1'b0, 1'b1, 1'b1);

        // backpressure mid-frame
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b0, 1'b1);
        repeat (15) tick(1'b0, 1'b1, 1'b1);

        // overflow: two stored, third dropped
        do_reset();
        for (int p = 0; p < 3; p++) begin
            rand_data();
            tick(1'b1, 1'b0, 1'b1);
            repeat (10) tick(1'b0, 1'b0, 1'b1);
        end
        check_eq("ovf_set", 32'(ovf), 32'd1);
        repeat (25) tick(1'b0, 1'b1, 1'b1);
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        check_eq("hdr_after_drop", tdata, 32'hA508_0003);
        repeat (15) tick(1'b0, 1'b1, 1'b1);

        // resync clears overflow, then capture coincident with the freeing ch7 handshake
        tick(1'b0, 1'b1, 1'b0);
        rand_data();
        tick(1'b1, 1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b1);
        rand_data();
        tick(1'b1, 1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() != 0 && exp_q[0].last && frames_in == 2) begin
                found = 1'b1;
                break;
            end
            tick(1'b0, 1'b1, 1'b1);
        end
        check_eq("sim_point_found", 32'(found), 32'd1);
        rand_data();
        tick(found, 1'b1, 1'b1);
        check_eq("sim_no_drop", 32'(ovf), 32'd0);
        repeat (30) tick(1'b0, 1'b1, 1'b1);

        // resync restarts frame numbering
        tick(1'b0, 1'b1, 1'b0);
        repeat (12) tick(1'b0, 1'b1, 1'b1);
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        check_eq("hdr_after_sync", tdata, 32'hA508_0000);
        repeat (15) tick(1'b0, 1'b1, 1'b1);

        // reset mid-frame after four words
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b1, 1'b1);
        do_reset();
        repeat (5) tick(1'b0, 1'b1, 1'b1);
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        check_eq("hdr_after_reset", tdata, 32'hA508_0000);
        repeat (15) tick(1'b0, 1'b1, 1'b1);

`ifdef FRAMER_TIMESTAMP_EN
        do_reset();
        repeat (1000) tick(1'b0, 1'b1, 1'b1);
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check_eq("ts_1000", tdata, 32'd1000);
        repeat (15) tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        repeat (19) tick(1'b0, 1'b1, 1'b1);
        rand_data();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check_eq("ts_after_sync", tdata, 32'd19);
        repeat (15) tick(1'b0, 1'b1, 1'b1);
`endif

        // randomized traffic with backpressure and occasional resync
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            logic dr;
            logic rdy;
            logic sn;
            dr  = (gap >= 10) && ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            sn  = dr ? 1'b1 : ($urandom_range(0, 299) != 0);
            if (dr) rand_data();
            gap = dr ? 0 : gap + 1;
            tick(dr, rdy, sn);
        end
        repeat (40) tick(1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
